// File: rtl/elevator_service_ctrl.sv
// Single-car elevator controller: SCAN-style service of a latched request vector.
// All direction and service decisions are taken in IDLE. Moves and door dwell are fixed-length timed states.
module elevator_service_ctrl #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           req,
    output logic [WIDTH-1:0]           off,
    output logic [$clog2(WIDTH)-1:0]   floor,
    output logic                       dir_up,
    output logic                       moving,
    output logic                       door_open
);

    localparam int unsigned FW   = $clog2(WIDTH);
    localparam int unsigned CMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_up_q, dir_up_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  off_q, off_d;
    logic              moving_q, moving_d;
    logic              door_q, door_d;

    logic              here;
    logic              above;
    logic              below;
    logic [WIDTH-1:0]  floor_hot;

    // Classify pending requests relative to the current floor
    always_comb begin
        here      = 1'b0;
        above     = 1'b0;
        below     = 1'b0;
        floor_hot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (FW'(i) == floor_q) begin
                here         = req[i];
                floor_hot[i] = 1'b1;
            end else if (FW'(i) > floor_q) begin
                above = above | req[i];
            end else begin
                below = below | req[i];
            end
        end
    end

    // Next-state, floor/direction update and registered-output next values
    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_up_d = dir_up_q;
        cnt_d    = '0;
        off_d    = '0;

        case (state_q)
            IDLE: begin
                if (here) begin
                    state_d = DOOR_OPEN;
                    off_d   = floor_hot;
                end else if (dir_up_q && above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end else if (above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end
            end
            MOVE_UP: begin
                if (cnt_q == MOVE_LAST) begin
                    state_d = IDLE;
                    if (floor_q != TOP_FLOOR) begin
                        floor_d = floor_q + FW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            MOVE_DOWN: begin
                if (cnt_q == MOVE_LAST) begin
                    state_d = IDLE;
                    if (floor_q != '0) begin
                        floor_d = floor_q - FW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DOOR_OPEN: begin
                if (cnt_q == DOOR_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        moving_d = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
        door_d   = (state_d == DOOR_OPEN);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_up_q <= 1'b1;
            cnt_q    <= '0;
            off_q    <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_up_q <= dir_up_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            moving_q <= moving_d;
            door_q   <= door_d;
        end
    end

    assign off       = off_q;
    assign floor     = floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_q;

endmodule

// File: tb/tb_elevator_service_ctrl.sv
// Scoreboard bench for elevator_service_ctrl: expected off pulses are queued when requests are raised.
// Each off pulse from the DUT is popped from the queue and checked. Cycle-exact trace checks are added on top.
module tb_elevator_service_ctrl;

    localparam int unsigned W = 5;

    logic          clk;
    logic          rst;
    logic [W-1:0]  req;
    logic [W-1:0]  off;
    logic [2:0]    floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;

    logic [W-1:0]  sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    elevator_service_ctrl #(
        .WIDTH       (5),
        .MOVE_CYCLES (4),
        .DOOR_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .off       (off),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance to the next falling edge, score any off pulse and clear the served bits from the latch model
    task automatic tick();
        logic [W-1:0] e;
        @(negedge clk);
        if (off !== '0) begin
            if (sb_q.size() == 0) begin
                check_eq("off_unexpected", 32'(off), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("off_served", 32'(off), 32'(e));
                check_eq("door_with_off", 32'(door_open), 32'd1);
            end
            req = req & ~off;
        end
    endtask

    task automatic settle(input string tag, input int max_cyc);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
            done = !moving && !door_open && (sb_q.size() == 0);
        end
        check_eq({tag, "_settle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_moving(input string tag, input int max_cyc);
        int n = 0;
        while (!moving && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq({tag, "_wait_move"}, 32'(moving), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check_eq("rst_floor", 32'(floor), 32'd0);
        check_eq("rst_dir_up", 32'(dir_up), 32'd1);
        check_eq("rst_moving", 32'(moving), 32'd0);
        check_eq("rst_door", 32'(door_open), 32'd0);
        check_eq("rst_off", 32'(off), 32'd0);

        // Floor 0 -> floor 2, cycle-exact trace
        rst = 1'b0;
        req = 5'b00100;
        sb_q.push_back(5'b00100);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_eq($sformatf("trace%0d_moving", k), 32'(moving),
                     32'((k >= 1 && k <= 4) || (k >= 6 && k <= 9)));
            check_eq($sformatf("trace%0d_floor", k), 32'(floor),
                     (k < 5) ? 32'd0 : ((k < 10) ? 32'd1 : 32'd2));
            check_eq($sformatf("trace%0d_door", k), 32'(door_open),
                     32'(k >= 11 && k <= 13));
            check_eq($sformatf("trace%0d_off", k), 32'(off),
                     (k == 11) ? 32'h04 : 32'h00);
        end

        // Request at current floor, then re-raised during the door dwell
        req = 5'b00100;
        sb_q.push_back(5'b00100);
        tick();
        check_eq("here_door", 32'(door_open), 32'd1);
        check_eq("here_moving", 32'(moving), 32'd0);
        check_eq("here_off", 32'(off), 32'h04);
        tick();
        req = 5'b00100;
        sb_q.push_back(5'b00100);
        tick();
        check_eq("reraise_door3", 32'(door_open), 32'd1);
        tick();
        check_eq("reraise_idle_door", 32'(door_open), 32'd0);
        check_eq("reraise_idle_off", 32'(off), 32'd0);
        tick();
        check_eq("reraise_door", 32'(door_open), 32'd1);
        check_eq("reraise_off", 32'(off), 32'h04);
        settle("reraise", 10);

        // SCAN with dir_up=1 from floor 2: serve 4 then 0
        check_eq("scan_up_dir", 32'(dir_up), 32'd1);
        check_eq("scan_up_floor", 32'(floor), 32'd2);
        req = 5'b10001;
        sb_q.push_back(5'b10000);
        sb_q.push_back(5'b00001);
        for (int n = 0; n < 40 && sb_q.size() > 1; n++) tick();
        check_eq("scan_up_first", 32'(sb_q.size()), 32'd1);
        wait_moving("scan_up_down", 20);
        check_eq("scan_up_flip_dir", 32'(dir_up), 32'd0);
        check_eq("scan_up_flip_floor", 32'(floor), 32'd4);
        settle("scan_up", 60);
        check_eq("scan_up_end_floor", 32'(floor), 32'd0);

        // Position at floor 2 travelling down
        req = 5'b01000;
        sb_q.push_back(5'b01000);
        settle("pos3", 40);
        check_eq("pos3_floor", 32'(floor), 32'd3);
        check_eq("pos3_dir", 32'(dir_up), 32'd1);
        req = 5'b00100;
        sb_q.push_back(5'b00100);
        settle("pos2", 20);
        check_eq("pos2_floor", 32'(floor), 32'd2);
        check_eq("pos2_dir", 32'(dir_up), 32'd0);

        // SCAN with dir_up=0 from floor 2: serve 0 then 4
        req = 5'b10001;
        sb_q.push_back(5'b00001);
        sb_q.push_back(5'b10000);
        wait_moving("scan_dn", 5);
        check_eq("scan_dn_dir", 32'(dir_up), 32'd0);
        settle("scan_dn", 80);
        check_eq("scan_dn_end_floor", 32'(floor), 32'd4);
        check_eq("scan_dn_end_dir", 32'(dir_up), 32'd1);

        // Reset while the door is open at floor 3, with a request pending at floor 0
        req = 5'b01000;
        sb_q.push_back(5'b01000);
        for (int n = 0; n < 20 && !door_open; n++) tick();
        check_eq("door3_open", 32'(door_open), 32'd1);
        check_eq("door3_floor", 32'(floor), 32'd3);
        check_eq("door3_dir", 32'(dir_up), 32'd0);
        rst = 1'b1;
        req = 5'b00001;
        tick();
        check_eq("rst_door_floor", 32'(floor), 32'd0);
        check_eq("rst_door_dir", 32'(dir_up), 32'd1);
        check_eq("rst_door_off", 32'(off), 32'd0);
        check_eq("rst_door_moving", 32'(moving), 32'd0);
        check_eq("rst_door_door", 32'(door_open), 32'd0);
        rst = 1'b0;
        sb_q.push_back(5'b00001);
        tick();
        check_eq("post_rst_door", 32'(door_open), 32'd1);
        settle("post_rst", 10);

        // Request dropped mid-move: step still completes, no service
        req = 5'b00010;
        wait_moving("drop", 5);
        req = '0;
        settle("drop", 20);
        check_eq("drop_floor", 32'(floor), 32'd1);
        check_eq("drop_door", 32'(door_open), 32'd0);

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
